// File: rtl/dm_store_buffer.sv
// Store buffer between the MEM stage and the data-memory write port: lane-aligns
// sb/sh/sw stores, queues them in order and drains them through a req/ack handshake.
module dm_store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [3:0]               m_dm_w_en,
   input  logic [AW-1:0]            m_addr,
   input  logic [31:0]              m_wdata,
   input  logic                     m_load,
   output logic                     stall_o,
   output logic                     misalign_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     mem_req,
   output logic [AW-1:0]            mem_addr,
   output logic [3:0]               mem_be,
   output logic [31:0]              mem_wdata,
   input  logic                     mem_ack
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Any enable pattern other than none/sb/sh/sw, or a sh/sw not on its natural boundary.
   function automatic logic is_misaligned(input logic [3:0] en, input logic [1:0] off);
      logic mis;
      case (en)
         4'b0000: mis = 1'b0;
         4'b0001: mis = 1'b0;
         4'b0011: mis = off[0];
         4'b1111: mis = (off != 2'b00);
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

   function automatic logic [3:0] lane_be(input logic [3:0] en, input logic [1:0] off);
      return 4'(en << off);
   endfunction

   function automatic logic [31:0] lane_data(input logic [31:0] d, input logic [1:0] off);
      return d << {off, 3'b000};
   endfunction

   logic [AW-1:0]  addr_r  [DEPTH];
   logic [3:0]     be_r    [DEPTH];
   logic [31:0]    wdata_r [DEPTH];
   logic [DEPTH-1:0] valid_r;
   logic [PW-1:0]  wr_ptr_r;
   logic [PW-1:0]  rd_ptr_r;
   logic [CW-1:0]  count_r;
   logic           misalign_r;

   logic [1:0]     off_s;
   logic [AW-1:0]  word_s;
   logic [3:0]     be_s;
   logic [31:0]    wdata_s;
   logic           store_v_s;
   logic           mis_s;
   logic           full_s;
   logic           match_s;
   logic           hit_s;
   logic           stall_s;
   logic           push_s;
   logic           pop_s;
   logic           req_s;

   // Lane alignment and classification of the incoming MEM-stage store.
   always_comb begin
      off_s     = m_addr[1:0];
      word_s    = {m_addr[AW-1:2], 2'b00};
      be_s      = lane_be(m_dm_w_en, off_s);
      wdata_s   = lane_data(m_wdata, off_s);
      store_v_s = (m_dm_w_en != 4'b0000);
      mis_s     = is_misaligned(m_dm_w_en, off_s);
   end

   // Load-hit detection against every pending word, head included.
   always_comb begin
      match_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_r[i] && (addr_r[i] == word_s)) begin
            match_s = 1'b1;
         end else begin
            match_s = match_s;
         end
      end
      hit_s = m_load & match_s;
   end

   // Handshake and stall decisions; a pop in the same cycle does not relieve a full stall.
   always_comb begin
      full_s  = (count_r == CW'(DEPTH));
      stall_s = (store_v_s & full_s) | hit_s;
      push_s  = store_v_s & ~stall_s & ~mis_s;
      req_s   = (count_r != {CW{1'b0}});
      pop_s   = req_s & mem_ack;
   end

   // FIFO storage, pointers, occupancy and valid bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_r[i]  <= {AW{1'b0}};
            be_r[i]    <= 4'b0000;
            wdata_r[i] <= 32'h0000_0000;
         end
         valid_r  <= {DEPTH{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            addr_r[wr_ptr_r]  <= word_s;
            be_r[wr_ptr_r]    <= be_s;
            wdata_r[wr_ptr_r] <= wdata_s;
            valid_r[wr_ptr_r] <= 1'b1;
            wr_ptr_r          <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end
         // Push and pop never target the same slot: push needs not-full, pop needs not-empty.
         if (pop_s) begin
            valid_r[rd_ptr_r] <= 1'b0;
            rd_ptr_r          <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
      end
   end

   // One-cycle pulse for a store that was dropped as misaligned.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         misalign_r <= 1'b0;
      end else begin
         misalign_r <= store_v_s & ~stall_s & mis_s;
      end
   end

   // Head entry presented to memory; zeroed while the queue is empty.
   always_comb begin
      if (req_s) begin
         mem_addr  = addr_r[rd_ptr_r];
         mem_be    = be_r[rd_ptr_r];
         mem_wdata = wdata_r[rd_ptr_r];
      end else begin
         mem_addr  = {AW{1'b0}};
         mem_be    = 4'b0000;
         mem_wdata = 32'h0000_0000;
      end
   end

   assign mem_req    = req_s;
   assign stall_o    = stall_s;
   assign misalign_o = misalign_r;
   assign count_o    = count_r;

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer with hand-computed expectations and an
// in-order address/data model for the pointer-wrap section.
module tb_dm_store_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  m_dm_w_en = 4'b0000;
   logic [31:0] m_addr = 32'h0;
   logic [31:0] m_wdata = 32'h0;
   logic        m_load = 1'b0;
   logic        mem_ack = 1'b0;
   logic        stall_o;
   logic        misalign_o;
   logic [2:0]  count_o;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;

   int n_vec = 0;
   int n_err = 0;

   dm_store_buffer #(.DEPTH(4), .AW(32)) dut (
      .clk(clk), .rst(rst), .m_dm_w_en(m_dm_w_en), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_load(m_load), .stall_o(stall_o), .misalign_o(misalign_o), .count_o(count_o),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] en, input logic [31:0] a, input logic [31:0] d,
                        input logic ld, input logic ack);
      m_dm_w_en = en;
      m_addr    = a;
      m_wdata   = d;
      m_load    = ld;
      mem_ack   = ack;
      #1;
   endtask

   task automatic idle();
      drive(4'b0000, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   logic [31:0] exp_q[$];

   initial begin
      // reset state
      #12;
      chk("rst_req", {31'b0, mem_req}, 32'd0);
      chk("rst_stall", {31'b0, stall_o}, 32'd0);
      chk("rst_mis", {31'b0, misalign_o}, 32'd0);
      chk("rst_cnt", {29'b0, count_o}, 32'd0);
      chk("rst_be", {28'b0, mem_be}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wd", mem_wdata, 32'd0);
      rst = 1'b1;
      tick();

      // 1: sb at 0x103
      drive(4'b0001, 32'h103, 32'h0000_00AB, 1'b0, 1'b0);
      chk("t1_stall", {31'b0, stall_o}, 32'd0);
      tick();
      idle();
      chk("t1_req", {31'b0, mem_req}, 32'd1);
      chk("t1_addr", mem_addr, 32'h100);
      chk("t1_be", {28'b0, mem_be}, 32'b1000);
      chk("t1_wd", mem_wdata, 32'hAB00_0000);
      drive(4'b0000, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      idle();
      chk("t1_cnt", {29'b0, count_o}, 32'd0);
      chk("t1_req0", {31'b0, mem_req}, 32'd0);

      // 2: fill, full stall, pop frees a slot
      for (int i = 0; i < 4; i++) begin
         drive(4'b1111, 32'h10 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
         tick();
      end
      drive(4'b1111, 32'h20, 32'hC000_0004, 1'b0, 1'b0);
      chk("t2_cnt4", {29'b0, count_o}, 32'd4);
      chk("t2_head", mem_addr, 32'h10);
      chk("t2_stall", {31'b0, stall_o}, 32'd1);
      tick();
      chk("t2_nopush", {29'b0, count_o}, 32'd4);
      drive(4'b1111, 32'h20, 32'hC000_0004, 1'b0, 1'b1);
      chk("t2_stall_pop", {31'b0, stall_o}, 32'd1);
      tick();
      drive(4'b1111, 32'h20, 32'hC000_0004, 1'b0, 1'b0);
      chk("t2_cnt3", {29'b0, count_o}, 32'd3);
      chk("t2_stall_off", {31'b0, stall_o}, 32'd0);
      tick();
      idle();
      chk("t2_cnt4b", {29'b0, count_o}, 32'd4);
      for (int i = 1; i < 5; i++) begin
         chk("t2_order", mem_addr, 32'h10 + 32'(4 * i));
         chk("t2_data", mem_wdata, 32'hC000_0000 + 32'(i));
         drive(4'b0000, 32'h0, 32'h0, 1'b0, 1'b1);
         tick();
      end
      idle();
      chk("t2_empty", {29'b0, count_o}, 32'd0);

      // 3: load hit on pending sh
      drive(4'b0011, 32'h106, 32'h0000_1234, 1'b0, 1'b0);
      tick();
      drive(4'b0000, 32'h104, 32'h0, 1'b1, 1'b0);
      chk("t3_hit", {31'b0, stall_o}, 32'd1);
      chk("t3_be", {28'b0, mem_be}, 32'b1100);
      chk("t3_wd", mem_wdata, 32'h1234_0000);
      tick();
      chk("t3_hold", {31'b0, stall_o}, 32'd1);
      drive(4'b0000, 32'h108, 32'h0, 1'b1, 1'b0);
      chk("t3_miss", {31'b0, stall_o}, 32'd0);
      drive(4'b0000, 32'h104, 32'h0, 1'b1, 1'b1);
      chk("t3_hit_pop", {31'b0, stall_o}, 32'd1);
      tick();
      drive(4'b0000, 32'h104, 32'h0, 1'b1, 1'b0);
      chk("t3_release", {31'b0, stall_o}, 32'd0);
      idle();

      // 4: steady push+pop at count 2 across pointer wrap
      for (int i = 0; i < 2; i++) begin
         drive(4'b1111, 32'h200 + 32'(4 * i), (32'h200 + 32'(4 * i)) ^ 32'h55AA_0000, 1'b0, 1'b0);
         exp_q.push_back(32'h200 + 32'(4 * i));
         tick();
      end
      for (int i = 2; i < 10; i++) begin
         drive(4'b1111, 32'h200 + 32'(4 * i), (32'h200 + 32'(4 * i)) ^ 32'h55AA_0000, 1'b0, 1'b1);
         exp_q.push_back(32'h200 + 32'(4 * i));
         chk("t4_addr", mem_addr, exp_q[0]);
         chk("t4_wd", mem_wdata, exp_q[0] ^ 32'h55AA_0000);
         void'(exp_q.pop_front());
         tick();
         chk("t4_cnt", {29'b0, count_o}, 32'd2);
      end
      while (exp_q.size() != 0) begin
         drive(4'b0000, 32'h0, 32'h0, 1'b0, 1'b1);
         chk("t4_tail", mem_addr, exp_q[0]);
         void'(exp_q.pop_front());
         tick();
      end
      idle();
      chk("t4_empty", {29'b0, count_o}, 32'd0);

      // 5: misaligned sw and sh
      drive(4'b1111, 32'h102, 32'h1111_2222, 1'b0, 1'b0);
      tick();
      idle();
      chk("t5_sw_mis", {31'b0, misalign_o}, 32'd1);
      chk("t5_sw_cnt", {29'b0, count_o}, 32'd0);
      tick();
      chk("t5_sw_pulse", {31'b0, misalign_o}, 32'd0);
      drive(4'b0011, 32'h101, 32'h0000_3333, 1'b0, 1'b0);
      tick();
      idle();
      chk("t5_sh_mis", {31'b0, misalign_o}, 32'd1);
      chk("t5_sh_cnt", {29'b0, count_o}, 32'd0);
      tick();
      chk("t5_sh_pulse", {31'b0, misalign_o}, 32'd0);

      // 6: async reset mid-drain
      for (int i = 0; i < 3; i++) begin
         drive(4'b1111, 32'h400 + 32'(4 * i), 32'h0, 1'b0, 1'b0);
         tick();
      end
      idle();
      chk("t6_cnt3", {29'b0, count_o}, 32'd3);
      chk("t6_req", {31'b0, mem_req}, 32'd1);
      rst = 1'b0;
      #1;
      chk("t6_req_rst", {31'b0, mem_req}, 32'd0);
      chk("t6_cnt_rst", {29'b0, count_o}, 32'd0);
      tick();
      rst = 1'b1;
      drive(4'b1111, 32'h300, 32'hDEAD_BEEF, 1'b0, 1'b0);
      tick();
      idle();
      chk("t6_new_req", {31'b0, mem_req}, 32'd1);
      chk("t6_new_addr", mem_addr, 32'h300);
      chk("t6_new_be", {28'b0, mem_be}, 32'b1111);
      chk("t6_new_wd", mem_wdata, 32'hDEAD_BEEF);
      drive(4'b0000, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      idle();
      chk("t6_drained", {29'b0, count_o}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
